// File: rtl/phase_sequencer_4_pkg.sv
// Shared encodings and widths for the four-phase instruction-cycle sequencer.
package phase_sequencer_4_pkg;

  localparam int unsigned PHASE_COUNT     = 4;
  localparam int unsigned CYCLE_CNT_WIDTH = 8;
  localparam int unsigned STATE_WIDTH     = 3;

  // Sequencer states; codes 6 and 7 are unreachable and recover to ST_IDLE.
  typedef enum logic [STATE_WIDTH-1:0] {
    ST_IDLE   = 3'd0,
    ST_P1     = 3'd1,
    ST_P2     = 3'd2,
    ST_P3     = 3'd3,
    ST_P4     = 3'd4,
    ST_HALTED = 3'd5
  } state_e;

endpackage : phase_sequencer_4_pkg

// File: rtl/phase_seq_counter.sv
// Async-reset wrapping incrementer used as the completed-instruction counter.
module phase_seq_counter
  import phase_sequencer_4_pkg::*;
#(
  parameter int unsigned WIDTH = CYCLE_CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: modulo 2^WIDTH increment when enabled.
  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : phase_seq_counter

// File: rtl/phase_sequencer_4.sv
// Registered one-hot four-phase sequencer (fetch/decode/execute/writeback)
// with stall, short-instruction skip and halt at instruction boundaries.
// Optional macro PHASE_SEQ_CYCLE_CNT_EN adds the 8-bit completed-instruction
// counter; without it Cycle_Count is tied to zero.
module phase_sequencer_4
  import phase_sequencer_4_pkg::*;
#(
  parameter int    UUID = 0,
  parameter string NAME = ""
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       Start,
  input  logic                       Stall,
  input  logic                       Short,
  input  logic                       Halt_Req,
  output logic                       Phase_1,
  output logic                       Phase_2,
  output logic                       Phase_3,
  output logic                       Phase_4,
  output logic                       Running,
  output logic                       Halted,
  output logic                       Instr_Done,
  output logic [CYCLE_CNT_WIDTH-1:0] Cycle_Count
);

  state_e                 state_q;
  state_e                 state_d;
  logic [PHASE_COUNT-1:0] phase_q;
  logic [PHASE_COUNT-1:0] phase_d;
  logic                   running_q;
  logic                   running_d;
  logic                   halted_q;
  logic                   halted_d;
  logic                   done_q;
  logic                   done_d;
  logic                   boundary;

  // Next state and the registered outputs that will accompany it.
  always_comb begin
    state_d  = state_q;
    boundary = 1'b0;
    unique case (state_q)
      ST_IDLE:   if (Start) state_d = ST_P1;
      ST_P1:     if (!Stall) state_d = ST_P2;
      ST_P2:     if (!Stall) state_d = ST_P3;
      ST_P3: begin
        if (!Stall) begin
          if (Short) boundary = 1'b1;
          else       state_d  = ST_P4;
        end
      end
      ST_P4:     if (!Stall) boundary = 1'b1;
      ST_HALTED: if (Start) state_d = ST_P1;
      default:   state_d = ST_IDLE;
    endcase
    if (boundary) begin
      state_d = Halt_Req ? ST_HALTED : ST_P1;
    end

    phase_d[0] = (state_d == ST_P1);
    phase_d[1] = (state_d == ST_P2);
    phase_d[2] = (state_d == ST_P3);
    phase_d[3] = (state_d == ST_P4);
    running_d  = |phase_d;
    halted_d   = (state_d == ST_HALTED);
    done_d     = boundary;
  end

  // State and output registers; reset discards any in-flight instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      running_q <= running_d;
      halted_q  <= halted_d;
      done_q    <= done_d;
    end
  end

  assign Phase_1    = phase_q[0];
  assign Phase_2    = phase_q[1];
  assign Phase_3    = phase_q[2];
  assign Phase_4    = phase_q[3];
  assign Running    = running_q;
  assign Halted     = halted_q;
  assign Instr_Done = done_q;

`ifdef PHASE_SEQ_CYCLE_CNT_EN
  // Completed-instruction counter advances on the same edge as Instr_Done.
  phase_seq_counter #(
    .WIDTH (CYCLE_CNT_WIDTH)
  ) u_counter (
    .clk   (clk),
    .rst   (rst),
    .en    (boundary),
    .count (Cycle_Count)
  );
`else
  assign Cycle_Count = '0;
`endif

endmodule : phase_sequencer_4

// File: tb/tb_phase_sequencer_4.sv
// Scoreboard bench for phase_sequencer_4: the driver pushes hand-computed
// expectations per cycle, the monitor pops and compares after each edge.
module tb_phase_sequencer_4;

  typedef struct packed {
    logic [3:0] phase;
    logic       running;
    logic       halted;
    logic       done;
    logic [7:0] count;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic       short_i = 1'b0;
  logic       halt_req = 1'b0;
  logic       ph1, ph2, ph3, ph4, running, halted, done;
  logic [7:0] cnt;

  obs_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   drv_done = 1'b0;

  phase_sequencer_4 #(.UUID(0), .NAME("tb")) dut (
    .clk         (clk),
    .rst         (rst),
    .Start       (start),
    .Stall       (stall),
    .Short       (short_i),
    .Halt_Req    (halt_req),
    .Phase_1     (ph1),
    .Phase_2     (ph2),
    .Phase_3     (ph3),
    .Phase_4     (ph4),
    .Running     (running),
    .Halted      (halted),
    .Instr_Done  (done),
    .Cycle_Count (cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ec(input int c);
`ifdef PHASE_SEQ_CYCLE_CNT_EN
    return 8'(c);
`else
    return 8'd0;
`endif
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.phase   = {ph4, ph3, ph2, ph1};
    o.running = running;
    o.halted  = halted;
    o.done    = done;
    o.count   = cnt;
    return o;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got ph=%b run=%b hlt=%b done=%b cnt=%0d, want ph=%b run=%b hlt=%b done=%b cnt=%0d",
               name, act.phase, act.running, act.halted, act.done, act.count,
               exp.phase, exp.running, exp.halted, exp.done, exp.count);
    end
  endtask

  // One cycle: drive inputs, push the expected post-edge outputs.
  // ph: 0 = no phase, 1..4 = Phase_n.
  task automatic step(input bit st, input bit sl, input bit sh, input bit hr,
                      input int ph, input bit hlt, input bit dn, input int c);
    obs_t e;
    @(negedge clk);
    start = st; stall = sl; short_i = sh; halt_req = hr;
    e.phase   = (ph == 0) ? 4'b0000 : 4'(1 << (ph - 1));
    e.running = (ph != 0);
    e.halted  = hlt;
    e.done    = dn;
    e.count   = ec(c);
    exp_q.push_back(e);
  endtask

  // Monitor: one comparison per clock edge while expectations are queued.
  initial begin
    obs_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cycle", observe(), e);
      end
    end
  end

  initial begin
    obs_t zero;
    zero = '0;
    #12;
    check("reset_state", observe(), zero);
    @(negedge clk);
    rst = 1'b0;

    // Idle with Start low, then a normal run of two instructions.
    step(0,0,0,0, 0,0,0,0);
    step(1,0,0,0, 1,0,0,0);
    step(0,0,0,0, 2,0,0,0);
    step(0,0,0,0, 3,0,0,0);
    step(0,0,0,0, 4,0,0,0);
    step(0,0,0,0, 1,0,1,1);
    step(0,0,0,0, 2,0,0,1);
    step(0,0,0,0, 3,0,0,1);
    step(0,0,0,0, 4,0,0,1);
    // Short held: three-cycle loop, five instructions.
    step(0,0,1,0, 1,0,1,2);
    for (int i = 0; i < 5; i++) begin
      step(0,0,1,0, 2,0,0,2+i);
      step(0,0,1,0, 3,0,0,2+i);
      step(0,0,1,0, 1,0,1,3+i);
    end
    // Stall three cycles entering P2.
    step(0,0,0,0, 2,0,0,7);
    step(0,1,0,0, 2,0,0,7);
    step(0,1,0,0, 2,0,0,7);
    step(0,1,0,0, 2,0,0,7);
    step(0,0,0,0, 3,0,0,7);
    step(0,0,0,0, 4,0,0,7);
    step(0,0,0,0, 1,0,1,8);
    // Halt requested during P2 completes the instruction, then halts.
    step(0,0,0,0, 2,0,0,8);
    step(0,0,0,1, 3,0,0,8);
    step(0,0,0,1, 4,0,0,8);
    step(0,0,0,1, 0,1,1,9);
    step(0,0,0,1, 0,1,0,9);
    step(1,0,0,0, 1,0,0,9);
    // Halt with stall in P4 waits for stall release.
    step(0,0,0,0, 2,0,0,9);
    step(0,0,0,0, 3,0,0,9);
    step(0,0,0,0, 4,0,0,9);
    step(0,1,0,1, 4,0,0,9);
    step(0,0,0,1, 0,1,1,10);
    step(1,0,0,0, 1,0,0,10);
    // Halt with short in P3 skips P4; Start ignored while running.
    step(0,0,0,0, 2,0,0,10);
    step(0,0,0,0, 3,0,0,10);
    step(0,0,1,1, 0,1,1,11);
    step(1,1,0,0, 1,0,0,11);
    step(1,0,0,0, 2,0,0,11);
    step(0,0,0,0, 3,0,0,11);
    step(0,0,0,0, 4,0,0,11);
    step(0,0,0,0, 1,0,1,12);
    // 256 short instructions: the counter wraps back to 12.
    for (int i = 0; i < 256; i++) begin
      step(0,0,1,0, 2,0,0,(12+i)%256);
      step(0,0,1,0, 3,0,0,(12+i)%256);
      step(0,0,1,0, 1,0,1,(13+i)%256);
    end
    // Reset mid-P3 clears outputs immediately and discards the instruction.
    step(0,0,0,0, 2,0,0,12);
    step(0,0,0,0, 3,0,0,12);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_reset", observe(), zero);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(0,0,0,0, 0,0,0,0);
    step(0,0,0,0, 0,0,0,0);
    step(1,0,0,0, 1,0,0,0);
    step(0,0,0,0, 2,0,0,0);
    drv_done = 1'b1;
  end

  // Drain the scoreboard with a bounded wait, then report.
  initial begin
    int guard;
    guard = 0;
    wait (drv_done);
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #5;
    if (exp_q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, limit 200000");
    $fatal(1);
  end

endmodule : tb_phase_sequencer_4
